// File: rtl/hnf_bump_pipe.sv
// Retiming pipeline for long HNF routes: a chain of 2-entry skid-buffer slices with a
// valid/ready handshake, synchronous flush and a registered occupancy count.
module hnf_bump_pipe #(
   parameter int DATA_WIDTH = 512,
   parameter int STAGES     = 2,
   parameter int BYPASS     = 0,
   localparam int OCC_W     = $clog2(2*STAGES+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [OCC_W-1:0]      occupancy,
   output logic                  idle
);

   generate
      if (BYPASS != 0) begin : g_bypass
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst};
         assign out_valid = in_valid & ~flush;
         assign out_data  = in_data;
         assign in_ready  = out_ready & ~flush;
         assign occupancy = '0;
         assign idle      = 1'b1;
      end else begin : g_pipe
         // Index k is the interface between slice k-1 and slice k.
         logic                  stage_valid [STAGES+1];
         logic                  stage_ready [STAGES+1];
         logic [DATA_WIDTH-1:0] stage_data  [STAGES+1];
         logic                  in_fire;
         logic                  out_fire;
         logic [OCC_W-1:0]      occ_reg;

         assign stage_valid[0]      = in_valid & rst & ~flush;
         assign stage_data[0]       = in_data;
         assign stage_ready[STAGES] = out_ready & ~flush;

         assign in_ready  = stage_ready[0] & rst & ~flush;
         assign out_valid = stage_valid[STAGES] & rst & ~flush;
         assign out_data  = stage_data[STAGES];
         assign in_fire   = in_valid & in_ready;
         assign out_fire  = out_valid & out_ready;

         for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
            logic                  main_valid_reg;
            logic                  skid_valid_reg;
            logic                  ready_reg;
            logic [DATA_WIDTH-1:0] main_data_reg;
            logic [DATA_WIDTH-1:0] skid_data_reg;
            logic                  slice_fire;
            logic                  main_free;

            assign slice_fire = stage_valid[gi] & ready_reg;
            // Main can take a new beat when it is empty or being consumed this edge.
            assign main_free  = ~main_valid_reg | stage_ready[gi+1];

            always_ff @(posedge clk) begin
               if (!rst) begin
                  main_valid_reg <= 1'b0;
                  skid_valid_reg <= 1'b0;
                  ready_reg      <= 1'b1;
                  main_data_reg  <= '0;
                  skid_data_reg  <= '0;
               end else if (flush) begin
                  main_valid_reg <= 1'b0;
                  skid_valid_reg <= 1'b0;
                  ready_reg      <= 1'b1;
               end else begin
                  if (main_free) begin
                     if (skid_valid_reg) begin
                        main_valid_reg <= 1'b1;
                        main_data_reg  <= skid_data_reg;
                        skid_valid_reg <= 1'b0;
                     end else begin
                        main_valid_reg <= slice_fire;
                        if (slice_fire) begin
                           main_data_reg <= stage_data[gi];
                        end
                     end
                  end else if (slice_fire) begin
                     skid_valid_reg <= 1'b1;
                     skid_data_reg  <= stage_data[gi];
                  end
                  // Ready mirrors next-cycle skid emptiness, so it never depends on downstream.
                  ready_reg <= main_free | ~(skid_valid_reg | slice_fire);
               end
            end

            assign stage_ready[gi]  = ready_reg;
            assign stage_valid[gi+1] = main_valid_reg;
            assign stage_data[gi+1]  = main_data_reg;
         end

         always_ff @(posedge clk) begin
            if (!rst || flush) begin
               occ_reg <= '0;
            end else if (in_fire && !out_fire) begin
               occ_reg <= occ_reg + OCC_W'(1);
            end else if (!in_fire && out_fire) begin
               occ_reg <= occ_reg - OCC_W'(1);
            end
         end

         assign occupancy = occ_reg;
         assign idle      = (occ_reg == '0);
      end
   endgenerate

endmodule

// File: tb/tb_hnf_bump_pipe.sv
// Randomised and directed bench for hnf_bump_pipe: a FIFO queue model tracks every accepted
// beat; order, occupancy, capacity, latency, flush/reset drop and bypass mode are checked.
module tb_hnf_bump_pipe;
   localparam int DW  = 32;
   localparam int ST  = 2;
   localparam int CAP = 2*ST;
   localparam int OW  = $clog2(2*ST+1);

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready, idle;
   logic [DW-1:0] in_data, out_data;
   logic [OW-1:0] occupancy;

   logic          b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_idle;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [OW-1:0] b_occupancy;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   logic [DW-1:0] q[$];
   bit            last_inf, last_outf, verbose;
   logic [DW-1:0] last_out_data;

   always #5 clk = ~clk;

   hnf_bump_pipe #(.DATA_WIDTH(DW), .STAGES(ST), .BYPASS(0)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .idle(idle));

   hnf_bump_pipe #(.DATA_WIDTH(DW), .STAGES(ST), .BYPASS(1)) dut_byp (
      .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .occupancy(b_occupancy), .idle(b_idle));

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: sample at negedge, update the model, then return 1 time unit after posedge.
   task automatic run_cycle();
      logic [DW-1:0] exp;
      @(negedge clk);
      last_inf  = 1'b0;
      last_outf = 1'b0;
      check_val("occ_vs_model", DW'(occupancy), DW'(q.size()));
      check_val("idle_vs_model", DW'(idle), DW'(q.size() == 0));
      if (flush) begin
         check_val("flush_in_ready", DW'(in_ready), 0);
         check_val("flush_out_valid", DW'(out_valid), 0);
         q.delete();
      end else if (rst) begin
         last_inf  = in_valid && in_ready;
         last_outf = out_valid && out_ready;
         if (q.size() == 0) check_val("out_valid_when_empty", DW'(out_valid), 0);
         if (last_outf && q.size() > 0) begin
            exp = q.pop_front();
            last_out_data = out_data;
            check_val("out_data", out_data, exp);
            if (verbose) $display("cycle %0d: out beat 0x%0h", cyc, out_data);
         end
         if (last_inf) begin
            q.push_back(in_data);
            if (verbose) $display("cycle %0d: in beat 0x%0h", cyc, in_data);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int sent, outs, first_fire, first_out, prev_out, cycles;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      b_rst = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      verbose = 1'b1;
      last_out_data = '0;

      // Reset hold, with in_valid high to show nothing is accepted.
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_in_ready", DW'(in_ready), 0);
      check_val("rst_out_valid", DW'(out_valid), 0);
      check_val("rst_occupancy", DW'(occupancy), 0);
      check_val("rst_idle", DW'(idle), 1);
      check_val("rst_out_data", out_data, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_val("release_in_ready", DW'(in_ready), 1);
      $display("reset: in_ready=%0b occupancy=%0d", in_ready, occupancy);
      @(posedge clk);
      #1;

      // Back-to-back stream 0x1..0x10.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
      sent = 0; outs = 0; first_fire = -1; first_out = -1; prev_out = -1;
      for (int i = 0; i < 40 && outs < 16; i++) begin
         run_cycle();
         if (last_outf) begin
            if (first_out < 0) first_out = cyc - 1;
            else check_val("stream_gap", DW'(cyc - 1 - prev_out), 1);
            prev_out = cyc - 1;
            outs++;
            if (last_inf) check_val("stream_occ", DW'(occupancy), 2);
         end
         if (last_inf) begin
            if (first_fire < 0) first_fire = cyc - 1;
            sent++;
            if (sent == 16) in_valid = 1'b0;
            else in_data = DW'(sent + 1);
         end
      end
      check_val("stream_count", DW'(outs), 16);
      check_val("stream_latency", DW'(first_out - first_fire), DW'(ST));

      // Backpressure fills exactly CAP entries, then drains in order.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h100; sent = 0;
      for (int i = 0; i < 12; i++) begin
         run_cycle();
         if (last_inf) begin
            sent++;
            in_data = in_data + 1;
         end
      end
      check_val("bp_fires", DW'(sent), DW'(CAP));
      check_val("bp_in_ready", DW'(in_ready), 0);
      check_val("bp_occupancy", DW'(occupancy), DW'(CAP));
      in_valid = 1'b0; out_ready = 1'b1; outs = 0;
      for (int i = 0; i < 12 && outs < CAP; i++) begin
         run_cycle();
         if (last_outf) outs++;
      end
      check_val("bp_drain_count", DW'(outs), DW'(CAP));
      check_val("bp_idle_after_drain", DW'(idle), 1);

      // Flush with three beats held and output stalled.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h200; sent = 0;
      for (int i = 0; i < 10 && sent < 3; i++) begin
         run_cycle();
         if (last_inf) begin
            sent++;
            in_data = in_data + 1;
         end
      end
      in_valid = 1'b0;
      check_val("pre_flush_occ", DW'(occupancy), 3);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hAB;
      run_cycle();
      flush = 1'b0;
      check_val("post_flush_occ", DW'(occupancy), 0);
      out_ready = 1'b1; outs = 0; last_out_data = '0;
      for (int i = 0; i < 10 && outs == 0; i++) begin
         run_cycle();
         if (last_inf) in_valid = 1'b0;
         if (last_outf) outs++;
      end
      check_val("flush_first_out", last_out_data, 32'hAB);
      $display("flush: first beat after flush 0x%0h", last_out_data);

      // Reset while stalled drops held beats.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h300;
      run_cycle();
      run_cycle();
      in_valid = 1'b0; rst = 1'b0;
      run_cycle();
      q.delete();
      rst = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) run_cycle();
      check_val("rst_drop_idle", DW'(idle), 1);

      // Randomised traffic: 50% valid, 30% ready.
      verbose = 1'b0;
      outs = 0; cycles = 0;
      in_valid = ($urandom_range(0, 1) == 0); in_data = $urandom;
      while (outs < 10000 && cycles < 60000) begin
         out_ready = ($urandom_range(0, 9) < 3);
         run_cycle();
         cycles++;
         check_val("occ_max", DW'(occupancy <= OW'(CAP)), 1);
         if (last_outf) begin
            outs++;
            if (outs % 1000 == 0) $display("random: %0d beats out at cycle %0d", outs, cyc);
         end
         if (last_inf || !in_valid) begin
            in_valid = ($urandom_range(0, 1) == 0);
            in_data  = $urandom;
         end
      end
      check_val("random_beats", DW'(outs), 10000);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) run_cycle();

      // Bypass build: combinational pass-through, rst held low.
      b_in_data = 32'hDEAD; b_in_valid = 1'b1; b_out_ready = 1'b1;
      #1;
      check_val("byp_out_valid", DW'(b_out_valid), 1);
      check_val("byp_out_data", b_out_data, 32'hDEAD);
      check_val("byp_in_ready", DW'(b_in_ready), 1);
      check_val("byp_occupancy", DW'(b_occupancy), 0);
      check_val("byp_idle", DW'(b_idle), 1);
      b_flush = 1'b1;
      #1;
      check_val("byp_flush_in_ready", DW'(b_in_ready), 0);
      check_val("byp_flush_out_valid", DW'(b_out_valid), 0);
      $display("bypass: data 0x%0h passed through", b_out_data);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
